// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH cycles, then pulses done.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic             br, br_next, d_bit;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;

  sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Result shift register holds WIDTH-1 bits; the final bit is merged in on the DONE transition.
  assign res_next = {d_bit, res};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      res  <= '0;
      br   <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_next[WIDTH-1:1];
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      // On the last bit a_sh[0]/b_sh[0] are the original operand MSBs.
      if (last_bit) begin
        diff <= res_next;
        bout <= br_next;
        ovf  <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed literal cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: countdown to the result, results computed with plain integer arithmetic.
  int unsigned  left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  bit           m_bout = 0, m_ovf = 0, p_bout = 0, p_ovf = 0;

  function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               output logic [W-1:0] d, output bit bo, output bit ov);
    longint full;
    full = longint'(x) - longint'(y) - longint'(c);
    d    = full[W-1:0];
    bo   = (full < 0);
    ov   = (x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      left = 0; m_done = 0; m_diff = '0; m_bout = 0; m_ovf = 0;
    end else if (left == 0) begin
      m_done = 0;
      if (start) begin
        calc(a, b, bin, p_diff, p_bout, p_ovf);
        left = W;
      end
    end else begin
      left--;
      if (left == 0) begin
        m_done = 1; m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ({busy, done, diff, bout, ovf} !== {left != 0, m_done, m_diff, m_bout, m_ovf}) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got busy=%b done=%b diff=%h bout=%b ovf=%b want busy=%b done=%b diff=%h bout=%b ovf=%b",
               $time, busy, done, diff, bout, ovf, left != 0, m_done, m_diff, m_bout, m_ovf);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    bit seen;
    a = x; b = y; bin = c; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 1; seen = 0;
    while (n <= 3 * W) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      step();
      n++;
    end
    check("latency", seen ? n : 0, W + 1);
    check("diff", diff, ed);
    check("bout", bout, eb);
    check("ovf", ovf, eo);
    step();
  endtask

  initial begin
    int cnt, last, ndone;
    logic [W-1:0] d_seen;

    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    check("reset_state", {busy, done, diff, bout, ovf}, '0);
    step();
    rst_n = 1'b1;
    step();

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Start re-pulsed mid-operation must be ignored.
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'hAA; b = 8'h11; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0; d_seen = '0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) begin cnt++; d_seen = diff; end
      step();
    end
    check("restart_done_count", cnt, 1);
    check("restart_diff", d_seen, 8'h02);

    // Reset mid-operation aborts with no done pulse.
    a = 8'h5A; b = 8'h33; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_outputs", {busy, done, diff, bout, ovf}, '0);
    cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_done_count", cnt, 0);
    step();
    run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Start held high: back-to-back operations every W+1 cycles.
    start = 1'b1;
    last = -1; ndone = 0;
    for (int i = 0; i < 6 * (W + 1); i++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("b2b_interval", i - last, W + 1);
        last = i;
        ndone++;
      end
      step();
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 5);
    repeat (2 * W) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2 * W) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
